// File: rtl/g729_seq_pkg.sv
// Shared types and constants for the G.729 per-frame stage sequencer.
package g729_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERROR  = 3'd5
  } seq_state_e;

  localparam logic [3:0] STG_PREPROC  = 4'd0;
  localparam logic [3:0] STG_AUTOCORR = 4'd1;
  localparam logic [3:0] STG_LAG      = 4'd2;
  localparam logic [3:0] STG_LEVINSON = 4'd3;
  localparam logic [3:0] STG_AZ       = 4'd4;
  localparam logic [3:0] STG_QUA_LSP  = 4'd5;
  localparam logic [3:0] STG_INT_LPC  = 4'd6;
  localparam logic [3:0] STG_INT_QLPC = 4'd7;
  localparam logic [3:0] STG_MATH1    = 4'd8;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_SPURIOUS = 2'd2;
  localparam logic [1:0] ERR_DIVERR   = 2'd3;

endpackage

// File: rtl/g729_stage_timer.sv
// Clearable saturating watchdog; o_expire flags the WAIT cycle whose increment reaches TIMEOUT_CYCLES.
module g729_stage_timer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && ((r_cnt == CNT_LAST) || (r_cnt == CNT_MAX));

endmodule

// File: rtl/g729_stage_sequencer.sv
// Issues one-cycle ready pulses to the nine encoder stages in order, owns the math-unit mux
// select, and aborts on divide error, out-of-order done or watchdog expiry.
module g729_stage_sequencer
  import g729_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 9,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MUXSEL_W       = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_div_err,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  output logic [NUM_STAGES-1:0] o_stage_ready,
  output logic [MUXSEL_W-1:0]   o_math_mux_sel,
  output logic [3:0]            o_cur_stage,
  output logic                  o_busy,
  output logic                  o_stage_pulse,
  output logic                  o_frame_done,
  output logic                  o_error,
  output logic [1:0]            o_err_code,
  output logic [2:0]            o_dbg_state
);

  // Handshake: a stage owns the math unit from its ready pulse until the cycle its done is
  // accepted; exactly one done bit (the active stage's) is legal, and only while waiting.

  localparam logic [3:0] LAST_K = 4'(NUM_STAGES - 1);

  seq_state_e r_state, w_state_nxt;
  logic [3:0]            r_k, w_k_nxt;
  logic [1:0]            r_code, w_code_nxt;
  logic                  w_pulse;
  logic                  w_expire;
  logic [NUM_STAGES-1:0] w_k_onehot;
  logic [NUM_STAGES-1:0] w_nxt_onehot;

  logic [NUM_STAGES-1:0] r_stage_ready;
  logic [MUXSEL_W-1:0]   r_mux_sel;
  logic                  r_busy, r_stage_pulse, r_frame_done, r_error;

  g729_stage_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk    (i_clock),
    .i_rst    (i_reset),
    .i_clear  (r_state == ST_ISSUE),
    .i_en     (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  assign w_k_onehot   = {{(NUM_STAGES-1){1'b0}}, 1'b1} << r_k;
  assign w_nxt_onehot = {{(NUM_STAGES-1){1'b0}}, 1'b1} << w_k_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_code_nxt  = r_code;
    w_pulse     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_k_nxt     = STG_PREPROC;
          w_code_nxt  = ERR_NONE;
          w_state_nxt = i_step_mode ? ST_HOLD : ST_ISSUE;
        end
      end
      ST_HOLD: begin
        if (i_step || !i_step_mode) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i_div_err) begin
          w_state_nxt = ST_ERROR;
          w_code_nxt  = ERR_DIVERR;
        end else if ((i_stage_done & ~w_k_onehot) != '0) begin
          w_state_nxt = ST_ERROR;
          w_code_nxt  = ERR_SPURIOUS;
        end else if (w_expire) begin
          w_state_nxt = ST_ERROR;
          w_code_nxt  = ERR_TIMEOUT;
        end else if ((i_stage_done & w_k_onehot) != '0) begin
          w_pulse = 1'b1;
          if (r_k == LAST_K) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_k_nxt     = r_k + 4'd1;
            w_state_nxt = i_step_mode ? ST_HOLD : ST_ISSUE;
          end
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      ST_ERROR: begin
        if (i_start) begin
          w_state_nxt = ST_IDLE;
          w_code_nxt  = ERR_NONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_k           <= STG_PREPROC;
      r_code        <= ERR_NONE;
      r_stage_ready <= '0;
      r_mux_sel     <= '0;
      r_busy        <= 1'b0;
      r_stage_pulse <= 1'b0;
      r_frame_done  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_k           <= w_k_nxt;
      r_code        <= w_code_nxt;
      r_stage_ready <= (w_state_nxt == ST_ISSUE) ? w_nxt_onehot : '0;
      r_mux_sel     <= ((w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT)) ?
                       (MUXSEL_W'(w_k_nxt) + MUXSEL_W'(1)) : '0;
      r_busy        <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_ISSUE) ||
                       (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_FINISH);
      r_stage_pulse <= w_pulse;
      r_frame_done  <= (w_state_nxt == ST_FINISH);
      r_error       <= (w_state_nxt == ST_ERROR);
    end
  end

  assign o_stage_ready  = r_stage_ready;
  assign o_math_mux_sel = r_mux_sel;
  assign o_cur_stage    = r_k;
  assign o_busy         = r_busy;
  assign o_stage_pulse  = r_stage_pulse;
  assign o_frame_done   = r_frame_done;
  assign o_error        = r_error;
  assign o_err_code     = r_code;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_g729_stage_sequencer.sv
// Directed bench for g729_stage_sequencer: nominal frame, step mode, and each abort path.
module tb_g729_stage_sequencer;
  import g729_seq_pkg::*;

  localparam int NS = 9;
  localparam int TO = 10;
  localparam int MW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic          div_err = 1'b0;
  logic [NS-1:0] done = '0;

  logic [NS-1:0] ready;
  logic [MW-1:0] mux_sel;
  logic [3:0]    cur_stage;
  logic          busy, stage_pulse, frame_done, error;
  logic [1:0]    err_code;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [NS-1:0] exp_q[$];

  g729_stage_sequencer #(
    .NUM_STAGES(NS), .TIMEOUT_CYCLES(TO), .MUXSEL_W(MW)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_step_mode    (step_mode),
    .i_step         (step),
    .i_div_err      (div_err),
    .i_stage_done   (done),
    .o_stage_ready  (ready),
    .o_math_mux_sel (mux_sel),
    .o_cur_stage    (cur_stage),
    .o_busy         (busy),
    .o_stage_pulse  (stage_pulse),
    .o_frame_done   (frame_done),
    .o_error        (error),
    .o_err_code     (err_code),
    .o_dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NS-1:0] onehot(input int k);
    logic [NS-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Starting in stage `first`'s ISSUE cycle, complete each stage with done in the cycle after ready.
  task automatic run_immediate(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      check_eq($sformatf("imm_ready_%0d", k), 32'(ready), 32'(onehot(k)));
      check_eq($sformatf("imm_mux_%0d", k), 32'(mux_sel), 32'(k + 1));
      tick();
      done = onehot(k);
      tick();
      done = '0;
      check_eq($sformatf("imm_pulse_%0d", k), 32'(stage_pulse), 32'd1);
    end
  endtask

  task automatic clear_error();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("clr_error", 32'(error), 32'd0);
    check_eq("clr_code", 32'(err_code), 32'(ERR_NONE));
    check_eq("clr_busy", 32'(busy), 32'd0);
    check_eq("clr_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    check_eq("clr_no_ready", 32'(ready), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_mux", 32'(mux_sel), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_stage", 32'(cur_stage), 32'd0);
    rst = 1'b0;
    tick();

    // nominal frame: done 3 cycles after each ready -> ready spacing 4
    for (int k = 0; k < NS; k++) exp_q.push_back(onehot(k));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NS; k++) begin
      check_eq($sformatf("nom_ready_%0d", k), 32'(ready), 32'(exp_q.pop_front()));
      check_eq($sformatf("nom_mux_%0d", k), 32'(mux_sel), 32'(k + 1));
      check_eq($sformatf("nom_stage_%0d", k), 32'(cur_stage), 32'(k));
      tick();
      check_eq($sformatf("nom_wait_ready_%0d", k), 32'(ready), 32'd0);
      tick();
      tick();
      done = onehot(k);
      tick();
      done = '0;
      check_eq($sformatf("nom_pulse_%0d", k), 32'(stage_pulse), 32'd1);
    end
    check_eq("nom_frame_done", 32'(frame_done), 32'd1);
    check_eq("nom_finish_busy", 32'(busy), 32'd1);
    check_eq("nom_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check_eq("nom_busy_low", 32'(busy), 32'd0);
    check_eq("nom_frame_done_once", 32'(frame_done), 32'd0);

    // step mode for stages 0..2, then release step_mode while held
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("step_hold_ready", 32'(ready), 32'd0);
    check_eq("step_hold_busy", 32'(busy), 32'd1);
    tick();
    check_eq("step_hold2_ready", 32'(ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("step_hold_mux_%0d", k), 32'(mux_sel), 32'd0);
      check_eq($sformatf("step_hold_stage_%0d", k), 32'(cur_stage), 32'(k));
      step = 1'b1;
      tick();
      step = 1'b0;
      check_eq($sformatf("step_ready_%0d", k), 32'(ready), 32'(onehot(k)));
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      check_eq($sformatf("step_in_wait_ready_%0d", k), 32'(ready), 32'd0);
      check_eq($sformatf("step_in_wait_mux_%0d", k), 32'(mux_sel), 32'(k + 1));
      done = onehot(k);
      tick();
      done = '0;
      check_eq($sformatf("step_pulse_%0d", k), 32'(stage_pulse), 32'd1);
      check_eq($sformatf("step_next_ready_%0d", k), 32'(ready), 32'd0);
    end
    step_mode = 1'b0;
    tick();
    run_immediate(3, NS - 1);
    check_eq("step_frame_done", 32'(frame_done), 32'd1);
    tick();
    check_eq("step_busy_low", 32'(busy), 32'd0);

    // divide error coincident with the expected done of stage 3
    start = 1'b1;
    tick();
    start = 1'b0;
    run_immediate(0, 2);
    tick();
    div_err = 1'b1;
    done = onehot(3);
    tick();
    div_err = 1'b0;
    done = '0;
    check_eq("div_error", 32'(error), 32'd1);
    check_eq("div_code", 32'(err_code), 32'(ERR_DIVERR));
    check_eq("div_no_pulse", 32'(stage_pulse), 32'd0);
    check_eq("div_mux", 32'(mux_sel), 32'd0);
    check_eq("div_busy", 32'(busy), 32'd0);
    div_err = 1'b1;
    tick();
    div_err = 1'b0;
    check_eq("div_sticky", 32'(error), 32'd1);
    check_eq("div_code_held", 32'(err_code), 32'(ERR_DIVERR));
    clear_error();

    // spurious done from stage 5 while waiting on stage 2
    start = 1'b1;
    tick();
    start = 1'b0;
    run_immediate(0, 1);
    tick();
    done = onehot(5);
    tick();
    done = '0;
    check_eq("spur_error", 32'(error), 32'd1);
    check_eq("spur_code", 32'(err_code), 32'(ERR_SPURIOUS));
    check_eq("spur_mux", 32'(mux_sel), 32'd0);
    check_eq("spur_stage", 32'(cur_stage), 32'd2);
    check_eq("spur_no_pulse", 32'(stage_pulse), 32'd0);
    clear_error();

    // timeout: stage 0 never completes
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("to_ready", 32'(ready), 32'(onehot(0)));
    for (int c = 1; c <= TO; c++) begin
      tick();
      check_eq($sformatf("to_pending_%0d", c), 32'(error), 32'd0);
    end
    tick();
    check_eq("to_error", 32'(error), 32'd1);
    check_eq("to_code", 32'(err_code), 32'(ERR_TIMEOUT));
    check_eq("to_busy", 32'(busy), 32'd0);
    clear_error();

    // asynchronous reset during stage 4 WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    run_immediate(0, 3);
    tick();
    check_eq("rmid_mux_before", 32'(mux_sel), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rmid_busy", 32'(busy), 32'd0);
    check_eq("rmid_mux", 32'(mux_sel), 32'd0);
    check_eq("rmid_stage", 32'(cur_stage), 32'd0);
    check_eq("rmid_frame_done", 32'(frame_done), 32'd0);
    check_eq("rmid_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("rmid_restart_ready", 32'(ready), 32'(onehot(0)));
    check_eq("rmid_restart_mux", 32'(mux_sel), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/g729_stage_sequencer.md
# g729_stage_sequencer

Registered sequencer for the G.729 encoder per-frame pipeline. It issues one-cycle ready pulses to the nine encoder stages in fixed order: preProc, autocorr, lag, levinson, Az, Qua_lsp, Int_lpc, Int_qlpc, Math1. It waits for each stage's done before issuing the next, and drives the shared math-unit mux select. It also supports single-step (debug) gating and aborts on divide error, spurious done or watchdog timeout. It sits between the top level and the pipe, and replaces the combinational ready/waiting gating.

## Interface
Parameters:
- NUM_STAGES, 9, number of sequenced stages; index 0 = preProc … 8 = Math1
- TIMEOUT_CYCLES, 65535, maximum cycles in WAIT before timeout; must be ≥ 1
- MUXSEL_W, 6, width of math_mux_sel

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin a frame (level sampled per cycle); ignored while busy
- step_mode  in  1  1 = hold before each stage issue until step
- step  in  1  single-cycle advance pulse, used only in step_mode
- div_err  in  1  divide error from pipe
- stage_done  in  NUM_STAGES  one-hot done pulses from stages
- stage_ready  out  NUM_STAGES  one-hot, one-cycle start pulse to stage k
- math_mux_sel  out  MUXSEL_W  shared math-unit owner: k+1 while stage k is active, 0 otherwise
- cur_stage  out  4  index of active or held stage
- busy  out  1  high from leaving IDLE until return to IDLE or ERROR
- stage_pulse  out  1  one-cycle pulse when the expected done is accepted
- frame_done  out  1  one-cycle pulse after stage NUM_STAGES-1 completes
- error  out  1  sticky; high in ERROR
- err_code  out  2  0 none, 1 timeout, 2 spurious done, 3 div_err

## Operation
- States: IDLE, HOLD, ISSUE, WAIT, FINISH, ERROR.
- IDLE + start → k=0, then HOLD if step_mode, else ISSUE.
- HOLD: outputs quiet, math_mux_sel=0. On step → ISSUE. step_mode deasserted in HOLD → ISSUE on the next cycle.
- ISSUE (one cycle): stage_ready[k]=1, math_mux_sel=k+1, watchdog cleared → WAIT.
- WAIT: math_mux_sel=k+1; watchdog increments each cycle.
  - Priority order when several conditions hold in the same cycle:
    - div_err → ERROR, code 3.
    - Any stage_done bit other than bit k → ERROR, code 2.
    - Watchdog reaches TIMEOUT_CYCLES → ERROR, code 1.
    - stage_done[k] → stage_pulse=1. If k=NUM_STAGES-1 → FINISH; otherwise k+1 and HOLD/ISSUE as selected by step_mode.
- FINISH (one cycle): frame_done=1 → IDLE.
- ERROR: stage_ready=0, math_mux_sel=0, error=1, err_code held. start clears error and err_code and returns to IDLE without starting a frame. div_err in ERROR is ignored.
- stage_done or div_err outside WAIT: ignored; no error raised.
- step outside HOLD: ignored.

## Timing
- Reset values: state IDLE, k=0, all outputs 0.
- Reset mid-frame aborts immediately. No frame_done is produced.
- All outputs are registered from state.
- Non-step latencies:
  - start sampled at edge n → stage_ready[0] high in cycle n+1.
  - stage_done[k] sampled at edge m → stage_pulse in cycle m+1 and stage_ready[k+1] in cycle m+1.
  - Last done at edge m → frame_done in cycle m+1, busy low in cycle m+2.
  - A stage that returns done in the cycle after its ready yields an inter-ready spacing of 2 cycles.
- Step mode: step sampled at edge s → stage_ready in cycle s+1.
- Watchdog: counter saturates; ERROR is entered on the cycle it equals TIMEOUT_CYCLES.

## Structure
- Package g729_seq_pkg:
  - State enum.
  - Stage index constants: STG_PREPROC … STG_MATH1.
  - Error code constants: ERR_NONE, ERR_TIMEOUT, ERR_SPURIOUS, ERR_DIVERR.
- Sub-module g729_stage_timer: clearable, saturating watchdog counter with a terminal-count flag; width derived from TIMEOUT_CYCLES.
- Top-level wiring: stage_ready fans out to the pipe's per-stage ready inputs; busy and stage_pulse replace the existing done OR-tree.

## Test plan
- Nominal frame: step_mode=0; each stage returns done 3 cycles after its ready → 9 ready pulses spaced 4 cycles apart; math_mux_sel steps 1..9; frame_done one cycle after the Math1 done; busy low the cycle after.
- Step mode: step_mode=1, immediate dones → no stage_ready until each step pulse; ready arrives exactly 1 cycle after step; step pulses in WAIT are ignored.
- Divide error: div_err during stage 3 WAIT, coincident with stage_done[3] → ERROR, err_code=3, no stage_pulse; start → IDLE, error=0, no stage_ready.
- Spurious done: stage_done[5] while waiting on stage 2 → ERROR, err_code=2, math_mux_sel=0.
- Timeout: TIMEOUT_CYCLES=10, stage 0 never completes → error asserted exactly 10 cycles after entering WAIT, err_code=1.
- Reset mid-frame: assert reset during stage 4 WAIT → all outputs 0 asynchronously; a later start begins at stage 0.
